// File: rtl/note_judge_pkg.sv
// Shared types, default parameters and the combo score multiplier for the note judge.
package note_judge_pkg;

   typedef enum logic [0:0] {IDLE = 1'b0, OPEN = 1'b1} judge_state_t;

   localparam int LANES_DEF     = 5;
   localparam int WINDOW_DEF    = 8;
   localparam int COMBO_MAX_DEF = 15;
   localparam int MAX_SCORE_DEF = 9999;
   localparam int DIGITS_DEF    = 4;

   // Pre-increment combo 0..3 -> 1x, 4..7 -> 2x, 8..11 -> 3x, 12+ -> 4x.
   function automatic logic [2:0] mult_f(input int unsigned combo);
      int unsigned q;
      q = combo >> 2;
      if (q > 3) q = 3;
      return 3'(q + 1);
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one load cycle then W shift cycles.
module bin2bcd_seq #(
   parameter int W      = 14,
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [W-1:0]        bin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(W + 1);

   logic          busy_q, busy_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  sh_q, sh_d;
   logic [BW-1:0] acc_q, acc_d, adj;
   logic [BW-1:0] bcd_q, bcd_d;

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      sh_d   = sh_q;
      acc_d  = acc_q;
      bcd_d  = bcd_q;
      adj    = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      if (busy_q) begin
         acc_d = BW'({adj, sh_q[W-1]});
         sh_d  = sh_q << 1;
         cnt_d = cnt_q - 1'b1;
         // Visible result only changes on the final shift, so bcd never shows partial values.
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            bcd_d  = acc_d;
         end
      end else if (start) begin
         busy_d = 1'b1;
         cnt_d  = CW'(W);
         sh_d   = bin;
         acc_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         sh_q   <= '0;
         acc_q  <= '0;
         bcd_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         sh_q   <= sh_d;
         acc_q  <= acc_d;
         bcd_q  <= bcd_d;
      end
   end

   assign busy = busy_q;
   assign done = busy_q && (cnt_q == CW'(1));
   assign bcd  = bcd_q;

endmodule

// File: rtl/note_judge_unit.sv
// Judges player chords against song notes inside a tick-counted window; keeps combo, score and BCD score.
//   state | meaning
//   IDLE  | no note armed, waiting for a non-rest note_valid
//   OPEN  | note armed, accumulating presses until hit, wrong fret or window expiry
module note_judge_unit
   import note_judge_pkg::*;
#(
   parameter int LANES     = LANES_DEF,
   parameter int WINDOW    = WINDOW_DEF,
   parameter int COMBO_MAX = COMBO_MAX_DEF,
   parameter int MAX_SCORE = MAX_SCORE_DEF,
   parameter int DIGITS    = DIGITS_DEF
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             tick,
   input  logic                             note_valid,
   input  logic [LANES-1:0]                 note,
   input  logic [LANES-1:0]                 btn,
   output logic                             hit,
   output logic                             miss,
   output logic                             window_open,
   output logic [$clog2(COMBO_MAX+1)-1:0]   combo,
   output logic [$clog2(MAX_SCORE+1)-1:0]   score,
   output logic [4*DIGITS-1:0]              bcd,
   output logic                             bcd_valid
);
   localparam int CW = $clog2(COMBO_MAX + 1);
   localparam int SW = $clog2(MAX_SCORE + 1);
   localparam int TW = $clog2(WINDOW + 1);

   judge_state_t   state_q, state_d;
   logic [LANES-1:0] target_q, target_d, acc_q, acc_d, btn_q, press, acc_nx;
   logic [TW-1:0]  cnt_q, cnt_d;
   logic           hit_q, hit_d, miss_q, miss_d, wopen_q;
   logic [CW-1:0]  combo_q, combo_d;
   logic [SW-1:0]  score_q, score_d;
   logic [SW:0]    sum;
   logic           pend_q, pend_d, bcd_valid_q, bcd_valid_d;
   logic           score_chg, conv_start, conv_busy, conv_done;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      hit_d    = 1'b0;
      miss_d   = 1'b0;
      combo_d  = combo_q;
      score_d  = score_q;
      press    = btn & ~btn_q;
      acc_nx   = acc_q | press;
      sum      = {1'b0, score_q} + (SW+1)'(mult_f(32'(combo_q)));

      if (state_q == OPEN) begin
         if (|(acc_nx & ~target_q))                            miss_d = 1'b1;
         else if (acc_nx == target_q)                          hit_d  = 1'b1;
         else if (note_valid || (tick && cnt_q == TW'(1)))     miss_d = 1'b1;
         else begin
            acc_d = acc_nx;
            if (tick) cnt_d = cnt_q - 1'b1;
         end
         if (hit_d || miss_d) state_d = IDLE;
      end

      // A note_valid while OPEN always resolves the old note above, so arming is state-independent.
      if (note_valid && note != '0) begin
         state_d  = OPEN;
         target_d = note;
         acc_d    = '0;
         cnt_d    = TW'(WINDOW);
      end

      if (hit_d) begin
         combo_d = (combo_q == CW'(COMBO_MAX)) ? combo_q : combo_q + 1'b1;
         score_d = (sum > (SW+1)'(MAX_SCORE)) ? SW'(MAX_SCORE) : sum[SW-1:0];
      end else if (miss_d) begin
         combo_d = '0;
      end

      score_chg   = (score_d != score_q);
      conv_start  = pend_q && !conv_busy;
      pend_d      = score_chg || (pend_q && !conv_start);
      bcd_valid_d = bcd_valid_q;
      if (score_chg)                 bcd_valid_d = 1'b0;
      else if (conv_done && !pend_q) bcd_valid_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         target_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         btn_q       <= '0;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         wopen_q     <= 1'b0;
         combo_q     <= '0;
         score_q     <= '0;
         pend_q      <= 1'b0;
         bcd_valid_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         btn_q       <= btn;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         wopen_q     <= (state_d == OPEN);
         combo_q     <= combo_d;
         score_q     <= score_d;
         pend_q      <= pend_d;
         bcd_valid_q <= bcd_valid_d;
      end
   end

   bin2bcd_seq #(.W(SW), .DIGITS(DIGITS)) u_bcd (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .bin   (score_q),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (bcd)
   );

   assign hit         = hit_q;
   assign miss        = miss_q;
   assign window_open = wopen_q;
   assign combo       = combo_q;
   assign score       = score_q;
   assign bcd_valid   = bcd_valid_q;

endmodule

// File: tb/tb_note_judge_unit.sv
// Directed bench for note_judge_unit: per-cycle vector table plus multi-cycle score/BCD/reset sequences.
module tb_note_judge_unit;

   typedef struct {
      logic        nv;
      logic [4:0]  note;
      logic [4:0]  btn;
      logic        tk;
      logic        hit;
      logic        miss;
      logic        wopen;
      logic [3:0]  combo;
      logic [13:0] score;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, tick, note_valid;
   logic [4:0]  note, btn;
   logic        hit, miss, window_open, bcd_valid;
   logic [3:0]  combo;
   logic [13:0] score;
   logic [15:0] bcd;

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   note_judge_unit dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .note_valid  (note_valid),
      .note        (note),
      .btn         (btn),
      .hit         (hit),
      .miss        (miss),
      .window_open (window_open),
      .combo       (combo),
      .score       (score),
      .bcd         (bcd),
      .bcd_valid   (bcd_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic nv, input logic [4:0] nt, input logic [4:0] b, input logic tk,
                      input logic h, input logic m, input logic o, input logic [3:0] c,
                      input logic [13:0] s);
      vec_t v;
      v.nv = nv; v.note = nt; v.btn = b; v.tk = tk;
      v.hit = h; v.miss = m; v.wopen = o; v.combo = c; v.score = s;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      note_valid = 1'b0; note = '0; btn = '0; tick = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
   endtask

   task automatic do_hit(input logic [4:0] lanes, output logic got);
      note_valid = 1'b1; note = lanes; btn = '0;
      step();
      note_valid = 1'b0; note = '0; btn = lanes;
      step();
      got = hit;
      btn = '0;
      step();
   endtask

   task automatic do_miss();
      note_valid = 1'b1; note = 5'b00001;
      step();
      note_valid = 1'b0; note = '0; btn = 5'b00010;
      step();
      btn = '0;
      step();
   endtask

   task automatic wait_bcd(input string name);
      for (int i = 0; i < 100; i++) begin
         if (bcd_valid === 1'b1) break;
         step();
      end
      chk({name, ".bcd_valid_timeout"}, 32'(bcd_valid), 32'd1);
   endtask

   initial begin
      logic got;
      int   pulses;
      logic valid_drop;

      // cycle vectors: inputs applied before the edge, outputs checked just after it
      add('0, 5'b00000, 5'b00000, '0, '0, '0, '0, 4'd0, 14'd0);
      add('1, 5'b00100, 5'b00000, '0, '0, '0, '1, 4'd0, 14'd0);
      for (int i = 0; i < 3; i++) add('0, 5'b00000, 5'b00000, '1, '0, '0, '1, 4'd0, 14'd0);
      add('0, 5'b00000, 5'b00100, '0, '1, '0, '0, 4'd1, 14'd1);
      add('0, 5'b00000, 5'b00100, '0, '0, '0, '0, 4'd1, 14'd1);
      add('0, 5'b00000, 5'b00000, '0, '0, '0, '0, 4'd1, 14'd1);
      add('1, 5'b10001, 5'b00000, '0, '0, '0, '1, 4'd1, 14'd1);
      add('0, 5'b00000, 5'b00001, '0, '0, '0, '1, 4'd1, 14'd1);
      add('0, 5'b00000, 5'b00001, '0, '0, '0, '1, 4'd1, 14'd1);
      add('0, 5'b00000, 5'b10001, '0, '1, '0, '0, 4'd2, 14'd2);
      add('0, 5'b00000, 5'b00000, '0, '0, '0, '0, 4'd2, 14'd2);
      add('1, 5'b10001, 5'b00000, '0, '0, '0, '1, 4'd2, 14'd2);
      add('0, 5'b00000, 5'b00010, '0, '0, '1, '0, 4'd0, 14'd2);
      add('0, 5'b00000, 5'b00000, '0, '0, '0, '0, 4'd0, 14'd2);
      add('1, 5'b01000, 5'b00000, '0, '0, '0, '1, 4'd0, 14'd2);
      for (int i = 0; i < 7; i++) add('0, 5'b00000, 5'b00000, '1, '0, '0, '1, 4'd0, 14'd2);
      add('0, 5'b00000, 5'b00000, '1, '0, '1, '0, 4'd0, 14'd2);
      add('0, 5'b00000, 5'b00000, '0, '0, '0, '0, 4'd0, 14'd2);
      add('1, 5'b00010, 5'b00000, '0, '0, '0, '1, 4'd0, 14'd2);
      add('1, 5'b00100, 5'b00000, '0, '0, '1, '1, 4'd0, 14'd2);
      add('0, 5'b00000, 5'b00100, '0, '1, '0, '0, 4'd1, 14'd3);
      add('0, 5'b00000, 5'b00000, '0, '0, '0, '0, 4'd1, 14'd3);
      add('1, 5'b00000, 5'b00000, '0, '0, '0, '0, 4'd1, 14'd3);
      add('1, 5'b00001, 5'b00000, '0, '0, '0, '1, 4'd1, 14'd3);
      add('0, 5'b00000, 5'b00011, '0, '0, '1, '0, 4'd0, 14'd3);
      add('0, 5'b00000, 5'b00000, '0, '0, '0, '0, 4'd0, 14'd3);
      add('1, 5'b00001, 5'b00000, '0, '0, '0, '1, 4'd0, 14'd3);
      for (int i = 0; i < 7; i++) add('0, 5'b00000, 5'b00000, '1, '0, '0, '1, 4'd0, 14'd3);
      add('0, 5'b00000, 5'b00001, '1, '1, '0, '0, 4'd1, 14'd4);
      add('0, 5'b00000, 5'b00000, '0, '0, '0, '0, 4'd1, 14'd4);

      // reset values while reset is held
      idle_inputs();
      reset = 1'b1;
      step(); step();
      chk("rst.hit",       32'(hit),         32'd0);
      chk("rst.miss",      32'(miss),        32'd0);
      chk("rst.open",      32'(window_open), 32'd0);
      chk("rst.combo",     32'(combo),       32'd0);
      chk("rst.score",     32'(score),       32'd0);
      chk("rst.bcd",       32'(bcd),         32'd0);
      chk("rst.bcd_valid", 32'(bcd_valid),   32'd1);
      reset = 1'b0;
      step();

      foreach (vecs[i]) begin
         note_valid = vecs[i].nv;
         note       = vecs[i].note;
         btn        = vecs[i].btn;
         tick       = vecs[i].tk;
         step();
         chk($sformatf("v%0d.hit", i),   32'(hit),         32'(vecs[i].hit));
         chk($sformatf("v%0d.miss", i),  32'(miss),        32'(vecs[i].miss));
         chk($sformatf("v%0d.open", i),  32'(window_open), 32'(vecs[i].wopen));
         chk($sformatf("v%0d.combo", i), 32'(combo),       32'(vecs[i].combo));
         chk($sformatf("v%0d.score", i), 32'(score),       32'(vecs[i].score));
      end
      idle_inputs();
      wait_bcd("table");
      chk("table.bcd", 32'(bcd), 32'h0004);

      // twelve consecutive hits, conversions overlapping score changes
      do_reset();
      for (int i = 0; i < 12; i++) do_hit(5'b00100, got);
      chk("x12.last_hit",     32'(got),       32'd1);
      chk("x12.score",        32'(score),     32'd24);
      chk("x12.combo",        32'(combo),     32'd12);
      chk("x12.bcd_valid_lo", 32'(bcd_valid), 32'd0);
      wait_bcd("x12");
      chk("x12.bcd", 32'(bcd), 32'h0024);

      // climb to 9998 at 4x, then saturate
      do_reset();
      do_hit(5'b00001, got);
      do_hit(5'b00001, got);
      do_miss();
      for (int i = 0; i < 2505; i++) do_hit(5'b00001, got);
      chk("sat.score_9998", 32'(score), 32'd9998);
      chk("sat.combo_max",  32'(combo), 32'd15);
      do_hit(5'b00001, got);
      chk("sat.hit",        32'(got),   32'd1);
      chk("sat.score_9999", 32'(score), 32'd9999);
      wait_bcd("sat");
      chk("sat.bcd", 32'(bcd), 32'h9999);
      do_hit(5'b00001, got);
      chk("sat.hit2",      32'(got),       32'd1);
      chk("sat.score_hold", 32'(score),    32'd9999);
      chk("sat.bcd_hold",  32'(bcd_valid), 32'd1);

      // reset while a note is armed and a conversion is in flight
      do_reset();
      do_hit(5'b00001, got);
      note_valid = 1'b1; note = 5'b00010;
      step();
      note_valid = 1'b0; note = '0;
      chk("mid.open_before",  32'(window_open), 32'd1);
      chk("mid.valid_before", 32'(bcd_valid),   32'd0);
      #2 reset = 1'b1;
      #1;
      chk("mid.open",      32'(window_open), 32'd0);
      chk("mid.combo",     32'(combo),       32'd0);
      chk("mid.score",     32'(score),       32'd0);
      chk("mid.bcd",       32'(bcd),         32'd0);
      chk("mid.bcd_valid", 32'(bcd_valid),   32'd1);
      step();
      reset = 1'b0;
      tick  = 1'b1;
      pulses = 0;
      valid_drop = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (hit === 1'b1 || miss === 1'b1) pulses++;
         if (bcd_valid !== 1'b1 || bcd !== 16'h0000) valid_drop = 1'b1;
      end
      tick = 1'b0;
      chk("mid.no_pulse",   32'(pulses),     32'd0);
      chk("mid.bcd_stable", 32'(valid_drop), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
